ka24_seq_ctrl: RTL and testbench

KA24_SEQ_CTRL -- requirements
Module: ka24_seq_ctrl

---
 rtl/ka24_seq_ctrl.sv | 129 ++++++++++++
 tb/tb_ka24_seq_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ka24_seq_ctrl.sv
`default_nettype none
// ============================================================================
// ka24_seq_ctrl
// Karatsuba sequencer: forms one NxN carry-less product from three HxH
// products computed on a shared external multiplier (LO, HI, MID).
// Revision: 1.0
// ============================================================================
module ka24_seq_ctrl #(
  parameter int N = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      a,
  input  logic [N-1:0]      b,
  output logic [N/2-1:0]    mul_a,
  output logic [N/2-1:0]    mul_b,
  input  logic [N-2:0]      mul_p,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*N-2:0]    result,
  output logic              busy
);

  // N must be even so that the operands split into two equal halves.
  localparam int H  = N / 2;
  localparam int PW = 2 * H - 1;
  localparam int RW = 2 * N - 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LO   = 3'd1,
    S_HI   = 3'd2,
    S_MID  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [PW-1:0] p0_q, p0_d;
  logic [PW-1:0] p2_q, p2_d;
  logic [RW-1:0] result_q, result_d;
  logic [PW-1:0] mid_term;
  logic          accept;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    p0_d     = p0_q;
    p2_d     = p2_q;
    result_d = result_q;
    mul_a    = '0;
    mul_b    = '0;
    mid_term = '0;
    in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    accept   = in_valid && in_ready;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d     = a;
          b_d     = b;
          state_d = S_LO;
        end
      end
      S_LO: begin
        mul_a   = a_q[H-1:0];
        mul_b   = b_q[H-1:0];
        p0_d    = mul_p;
        state_d = S_HI;
      end
      S_HI: begin
        mul_a   = a_q[N-1:H];
        mul_b   = b_q[N-1:H];
        p2_d    = mul_p;
        state_d = S_MID;
      end
      S_MID: begin
        mul_a    = a_q[H-1:0] ^ a_q[N-1:H];
        mul_b    = b_q[H-1:0] ^ b_q[N-1:H];
        // Middle Karatsuba term: (a0^a1)(b0^b1) ^ a0b0 ^ a1b1
        mid_term = mul_p ^ p0_q ^ p2_q;
        result_d = {{N{1'b0}}, p0_q}
                 ^ ({{N{1'b0}}, mid_term} << H)
                 ^ ({{N{1'b0}}, p2_q} << N);
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            a_d     = a;
            b_d     = b;
            state_d = S_LO;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      p0_q     <= '0;
      p2_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      p0_q     <= p0_d;
      p2_q     <= p2_d;
      result_q <= result_d;
    end
  end

  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign result    = result_q;

endmodule
`default_nettype wire

// File: tb/tb_ka24_seq_ctrl.sv
`default_nettype none
// ============================================================================
// tb_ka24_seq_ctrl
// Scoreboard bench: full-width carry-less reference, external multiplier model.
// Revision: 1.0
// ============================================================================
module tb_ka24_seq_ctrl;

  localparam int N = 24;
  localparam int H = N / 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N-1:0]   a = '0;
  logic [N-1:0]   b = '0;
  logic [H-1:0]   mul_a;
  logic [H-1:0]   mul_b;
  logic [N-2:0]   mul_p;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*N-2:0] result;
  logic           busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit rand_rdy  = 1'b0;
  bit rdy_fixed = 1'b1;

  typedef struct {
    logic [2*N-2:0] res;
    int             acc;
  } exp_t;
  exp_t exp_q[$];
  bit   seen_first = 1'b0;

  ka24_seq_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Plain shift-and-xor carry-less product.
  function automatic logic [127:0] clmul(input logic [63:0] x, input logic [63:0] y);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 64; i++)
      if (y[i]) r = r ^ ({64'b0, x} << i);
    return r;
  endfunction

  function automatic logic [N-1:0] rnd();
    logic [31:0] t;
    t = $urandom;
    return t[N-1:0];
  endfunction

  // External shared HxH multiplier
  logic [127:0] mul_full;
  assign mul_full = clmul(64'(mul_a), 64'(mul_b));
  assign mul_p    = mul_full[N-2:0];

  always @(posedge clk) begin
    #1;
    out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_fixed;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compares every presented result against the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      seen_first = 1'b0;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 64'(out_valid), 64'(0));
      end else begin
        chk("result", 64'(result), 64'(exp_q[0].res));
        chk("busy_done", 64'(busy), 64'(1));
        if (!seen_first) begin
          chk("latency", 64'(cyc - exp_q[0].acc), 64'(3));
          seen_first = 1'b1;
        end
        if (!out_ready) chk("in_ready_hold", 64'(in_ready), 64'(0));
        else begin
          void'(exp_q.pop_front());
          seen_first = 1'b0;
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [N-1:0] xa, input logic [N-1:0] xb, output int acc);
    int n;
    logic [127:0] full;
    exp_t e;
    n = 0;
    a = xa;
    b = xb;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout: actual in_ready=0 required in_ready=1");
      in_valid = 1'b0;
      acc = -1;
      return;
    end
    full  = clmul(64'(xa), 64'(xb));
    e.res = full[2*N-2:0];
    e.acc = cyc + 1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    acc = cyc;
    in_valid = 1'b0;
    a = rnd();
    b = rnd();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 500) begin
      errors++;
      $display("FAIL drain_timeout: actual pending=%0d required pending=0", exp_q.size());
    end
  endtask

  initial begin
    int acc1, acc2, n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_mul_a", 64'(mul_a), 64'(0));
    chk("rst_mul_b", 64'(mul_b), 64'(0));
    chk("rst_result", 64'(result), 64'(0));

    send(24'h000001, 24'h000001, acc1);
    drain();
    chk("unit_product", 64'(result), 64'h000000000001);
    send(24'h800000, 24'h800000, acc1);
    drain();
    chk("top_bits_product", 64'(result), 64'h400000000000);

    send(24'hFFFFFF, 24'h000003, acc1);
    chk("lo_mul_a", 64'(mul_a), 64'hFFF);
    chk("lo_mul_b", 64'(mul_b), 64'h003);
    @(posedge clk); #1;
    chk("hi_mul_a", 64'(mul_a), 64'hFFF);
    chk("hi_mul_b", 64'(mul_b), 64'h000);
    @(posedge clk); #1;
    chk("mid_mul_a", 64'(mul_a), 64'h000);
    chk("mid_mul_b", 64'(mul_b), 64'h003);
    drain();
    chk("ones_x3_product", 64'(result), 64'h000001000001);
    chk("idle_mul_a", 64'(mul_a), 64'h0);

    rdy_fixed = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    send(24'h001001, 24'h000003, acc1);
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #2; n++; end
    repeat (5) @(posedge clk);
    #2;
    chk("hold_out_valid", 64'(out_valid), 64'(1));
    chk("hold_result", 64'(result), 64'h000000003003);
    chk("hold_in_ready", 64'(in_ready), 64'(0));
    rdy_fixed = 1'b1;
    drain();

    send(rnd(), rnd(), acc1);
    send(rnd(), rnd(), acc2);
    chk("b2b_gap", 64'(acc2 - acc1), 64'(4));
    drain();

    rst = 1'b1;
    in_valid = 1'b1;
    a = 24'h000005;
    b = 24'h000007;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rst_prio_busy", 64'(busy), 64'(0));
    chk("rst_prio_in_ready", 64'(in_ready), 64'(1));
    repeat (6) @(posedge clk);
    #1;

    send(rnd(), rnd(), acc1);
    @(posedge clk); #1;
    chk("hi_busy", 64'(busy), 64'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_out_valid", 64'(out_valid), 64'(0));
    chk("abort_result", 64'(result), 64'(0));
    chk("abort_mul_a", 64'(mul_a), 64'(0));
    repeat (8) @(posedge clk);
    #1;

    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send(rnd(), rnd(), acc1);
    end
    rand_rdy = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
